// File: rtl/ws2812_pkg.sv
// Shared WS2812 definitions: decoder FSM states, word size, and the default bit
// timing used by both the ws2812 transmitter and this decoder.
package ws2812_pkg;

  typedef enum logic [1:0] {SYNC, IDLE, HIGH, LOW} state_t;

  localparam int WS2812_BITS = 24;

  // Transmitter bit shapes in clk cycles (10 MHz clk).
  localparam int T0H = 4;
  localparam int T0L = 8;
  localparam int T1H = 8;
  localparam int T1L = 4;

  // Receiver thresholds chosen to sit between the TX shapes above.
  localparam int DEF_HI_THRESH = 6;
  localparam int DEF_MIN_HIGH  = 2;
  localparam int DEF_MAX_HIGH  = 16;
  localparam int DEF_RESET_LOW = 500;

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for a single asynchronous input, cleared to 0 by an
// asynchronous active-low reset.
module sync_2ff (
  input  logic clk,
  input  logic reset_n,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      meta <= 1'b0;
      q    <= 1'b0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/ws2812_decoder.sv
// WS2812 receiver: measures high-pulse widths on the synchronized line, shifts
// bits into 24-bit GRB words and reports pixel, frame-end and error strobes.
module ws2812_decoder
  import ws2812_pkg::*;
#(
  parameter int HI_THRESH = DEF_HI_THRESH,
  parameter int MIN_HIGH  = DEF_MIN_HIGH,
  parameter int MAX_HIGH  = DEF_MAX_HIGH,
  parameter int RESET_LOW = DEF_RESET_LOW
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        din,
  output logic        pixel_valid,
  output logic [23:0] grb_data,
  output logic [7:0]  led_index,
  output logic        frame_done,
  output logic [8:0]  pixel_count,
  output logic        err
);

  localparam int HW = $clog2(MAX_HIGH + 1);
  localparam int LW = $clog2(RESET_LOW + 1);
  localparam logic [HW-1:0] HI_THRESH_C = HW'(HI_THRESH);
  localparam logic [HW-1:0] MIN_HIGH_C  = HW'(MIN_HIGH);
  localparam logic [HW-1:0] MAX_LAST_C  = HW'(MAX_HIGH - 1);
  localparam logic [LW-1:0] RESET_LOW_C = LW'(RESET_LOW);
  localparam logic [LW-1:0] RESET_LAST_C = LW'(RESET_LOW - 1);
  localparam logic [4:0]    LAST_BIT_C  = 5'(WS2812_BITS - 1);
  localparam logic [8:0]    PIX_MAX_C   = 9'd256;

  logic din_s, din_q, rise, fall;
  state_t state, state_n;
  logic [HW-1:0] hi_cnt, hi_cnt_n;
  logic [LW-1:0] lo_cnt, lo_cnt_n;
  logic [4:0]    bit_cnt, bit_cnt_n;
  logic [8:0]    pix_cnt, pix_cnt_n;
  logic [23:0]   shreg, shreg_n, shifted;
  logic          ovf, ovf_n;
  logic          pixel_valid_n, frame_done_n, err_n;
  logic [23:0]   grb_data_n;
  logic [7:0]    led_index_n;
  logic [8:0]    pixel_count_n;

  sync_2ff u_sync (
    .clk     (clk),
    .reset_n (reset_n),
    .d       (din),
    .q       (din_s)
  );

  assign rise = din_s & ~din_q;
  assign fall = ~din_s & din_q;

  always_comb begin
    state_n       = state;
    hi_cnt_n      = hi_cnt;
    lo_cnt_n      = lo_cnt;
    bit_cnt_n     = bit_cnt;
    pix_cnt_n     = pix_cnt;
    shreg_n       = shreg;
    ovf_n         = ovf;
    grb_data_n    = grb_data;
    led_index_n   = led_index;
    pixel_count_n = pixel_count;
    pixel_valid_n = 1'b0;
    frame_done_n  = 1'b0;
    err_n         = 1'b0;
    shifted       = {shreg[22:0], (hi_cnt >= HI_THRESH_C)};

    unique case (state)
      SYNC: begin
        if (din_s) begin
          lo_cnt_n = '0;
        end else if (lo_cnt >= RESET_LAST_C) begin
          lo_cnt_n = RESET_LOW_C;
          state_n  = IDLE;
        end else begin
          lo_cnt_n = lo_cnt + 1'b1;
        end
      end

      IDLE: begin
        if (rise) begin
          hi_cnt_n  = HW'(1);
          bit_cnt_n = '0;
          pix_cnt_n = '0;
          ovf_n     = 1'b0;
          state_n   = HIGH;
        end
      end

      HIGH: begin
        if (fall) begin
          lo_cnt_n = '0;
          if (hi_cnt < MIN_HIGH_C) begin
            err_n   = 1'b1;
            state_n = SYNC;
          end else begin
            shreg_n = shifted;
            state_n = LOW;
            if (bit_cnt == LAST_BIT_C) begin
              // Pixel completes on the falling edge that delivers bit 24.
              bit_cnt_n = '0;
              if (pix_cnt != PIX_MAX_C) begin
                pixel_valid_n = 1'b1;
                grb_data_n    = shifted;
                led_index_n   = pix_cnt[7:0];
                pix_cnt_n     = pix_cnt + 1'b1;
              end else if (!ovf) begin
                err_n = 1'b1;
                ovf_n = 1'b1;
              end
            end else begin
              bit_cnt_n = bit_cnt + 1'b1;
            end
          end
        end else if (hi_cnt >= MAX_LAST_C) begin
          err_n    = 1'b1;
          lo_cnt_n = '0;
          state_n  = SYNC;
        end else begin
          hi_cnt_n = hi_cnt + 1'b1;
        end
      end

      LOW: begin
        // Frame end takes priority over a rising edge in the same cycle.
        if (lo_cnt >= RESET_LAST_C) begin
          frame_done_n  = 1'b1;
          pixel_count_n = pix_cnt;
          err_n         = (bit_cnt != 5'd0);
          bit_cnt_n     = '0;
          lo_cnt_n      = RESET_LOW_C;
          state_n       = IDLE;
        end else if (rise) begin
          hi_cnt_n = HW'(1);
          state_n  = HIGH;
        end else begin
          lo_cnt_n = lo_cnt + 1'b1;
        end
      end

      default: state_n = SYNC;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state       <= SYNC;
      din_q       <= 1'b0;
      hi_cnt      <= '0;
      lo_cnt      <= '0;
      bit_cnt     <= '0;
      pix_cnt     <= '0;
      shreg       <= '0;
      ovf         <= 1'b0;
      pixel_valid <= 1'b0;
      grb_data    <= '0;
      led_index   <= '0;
      frame_done  <= 1'b0;
      pixel_count <= '0;
      err         <= 1'b0;
    end else begin
      state       <= state_n;
      din_q       <= din_s;
      hi_cnt      <= hi_cnt_n;
      lo_cnt      <= lo_cnt_n;
      bit_cnt     <= bit_cnt_n;
      pix_cnt     <= pix_cnt_n;
      shreg       <= shreg_n;
      ovf         <= ovf_n;
      pixel_valid <= pixel_valid_n;
      grb_data    <= grb_data_n;
      led_index   <= led_index_n;
      frame_done  <= frame_done_n;
      pixel_count <= pixel_count_n;
      err         <= err_n;
    end
  end

endmodule

// File: tb/tb_ws2812_decoder.sv
// Bench for ws2812_decoder: pulse-level driver, frame/pixel reference model,
// and a monitor that checks every strobe against queued expectations.
module tb_ws2812_decoder;
  import ws2812_pkg::*;

  localparam int RST_LOW = 500;
  localparam int MIN_HI  = 2;
  localparam int MAX_HI  = 16;
  localparam int THRESH  = 6;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        din = 1'b0;
  logic        pixel_valid;
  logic [23:0] grb_data;
  logic [7:0]  led_index;
  logic        frame_done;
  logic [8:0]  pixel_count;
  logic        err;

  int checks = 0;
  int failures = 0;

  logic [31:0] exp_pix_q[$];
  logic [9:0]  exp_frame_q[$];
  logic [1:0]  exp_err_q[$];

  // Model: 0 = not synchronized, 1 = at frame boundary, 2 = inside a frame.
  int          m_mode = 0;
  int          m_low_run = 0;
  int          m_bits = 0;
  int          m_total = 0;
  logic [23:0] m_word = '0;

  ws2812_decoder dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .din         (din),
    .pixel_valid (pixel_valid),
    .grb_data    (grb_data),
    .led_index   (led_index),
    .frame_done  (frame_done),
    .pixel_count (pixel_count),
    .err         (err)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic model_reset();
    m_mode = 0;
    m_low_run = 0;
  endtask

  task automatic model_high(input int n);
    logic [8:0] idx;
    if (m_mode == 0) begin
      m_low_run = 0;
      return;
    end
    if (m_mode == 1) begin
      m_mode  = 2;
      m_bits  = 0;
      m_total = 0;
    end
    if (n < MIN_HI || n >= MAX_HI) begin
      exp_err_q.push_back(2'd1);
      m_mode = 0;
      m_low_run = 0;
      return;
    end
    m_word = {m_word[22:0], (n >= THRESH)};
    m_bits++;
    if (m_bits == 24) begin
      m_bits = 0;
      if (m_total < 256) begin
        idx = 9'(m_total);
        exp_pix_q.push_back({idx[7:0], m_word});
      end else if (m_total == 256) begin
        exp_err_q.push_back(2'd2);
      end
      m_total++;
    end
  endtask

  task automatic model_low(input int n);
    logic [8:0] cnt;
    if (m_mode == 0) begin
      m_low_run += n;
      if (m_low_run >= RST_LOW) m_mode = 1;
    end else if (m_mode == 2 && n >= RST_LOW) begin
      cnt = (m_total > 256) ? 9'd256 : 9'(m_total);
      exp_frame_q.push_back({(m_bits != 0), cnt});
      m_mode = 1;
    end
  endtask

  // Called and returns at 1 time unit after a rising clock edge.
  task automatic hold(input logic v, input int n);
    din = v;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic pulse(input int hi, input int lo);
    model_high(hi);
    hold(1'b1, hi);
    model_low(lo);
    hold(1'b0, lo);
  endtask

  task automatic gap(input int n);
    model_low(n);
    hold(1'b0, n);
  endtask

  // mode 0: transmitter shapes, 1: shortest legal, 2: random legal, 3: threshold edges.
  task automatic send_bit(input logic b, input int mode);
    case (mode)
      0: if (b) pulse(T1H, T1L); else pulse(T0H, T0L);
      1: if (b) pulse(6, 1); else pulse(2, 1);
      2: if (b) pulse($urandom_range(15, 6), $urandom_range(10, 1));
         else   pulse($urandom_range(5, 2), $urandom_range(10, 1));
      default: if (b) pulse(6, 6); else pulse(5, 6);
    endcase
  endtask

  task automatic send_word(input logic [23:0] w, input int mode);
    for (int i = 23; i >= 0; i--) send_bit(w[i], mode);
  endtask

  always @(negedge clk) begin
    if (reset_n) begin
      if (pixel_valid) begin
        check("pv_fd_overlap", 64'(frame_done), 64'd0);
        check("pix_expected", 64'(exp_pix_q.size() != 0), 64'd1);
        if (exp_pix_q.size() != 0) check("pixel", {led_index, grb_data}, exp_pix_q.pop_front());
      end
      if (frame_done) begin
        check("frame_expected", 64'(exp_frame_q.size() != 0), 64'd1);
        if (exp_frame_q.size() != 0) check("frame", {err, pixel_count}, exp_frame_q.pop_front());
      end else if (err) begin
        check("err_expected", 64'(exp_err_q.size() != 0), 64'd1);
        if (exp_err_q.size() != 0) void'(exp_err_q.pop_front());
      end
    end
  end

  initial begin
    logic [23:0] w;
    repeat (3) @(posedge clk);
    #1;
    check("rst_pixel_valid", 64'(pixel_valid), 64'd0);
    check("rst_grb_data", 64'(grb_data), 64'd0);
    check("rst_led_index", 64'(led_index), 64'd0);
    check("rst_frame_done", 64'(frame_done), 64'd0);
    check("rst_pixel_count", 64'(pixel_count), 64'd0);
    check("rst_err", 64'(err), 64'd0);
    reset_n = 1'b1;
    model_reset();
    gap(600);

    send_word(24'hFF0055, 0);
    gap(600);

    send_word(24'h000001, 0);
    send_word(24'h800000, 0);
    send_word(24'hAAAAAA, 0);
    gap(600);

    send_word(24'($urandom()), 3);
    send_word(24'hA5F00F, 3);
    gap(600);

    // Glitch mid-frame: earlier pixel stands, rest ignored until resync.
    send_word(24'h123456, 0);
    for (int i = 0; i < 5; i++) send_bit(1'($urandom_range(1, 0)), 0);
    pulse(1, 8);
    send_word(24'hABCDEF, 0);
    gap(600);
    send_word(24'h5A5A5A, 0);
    gap(600);

    for (int i = 0; i < 12; i++) send_bit(1'($urandom_range(1, 0)), 0);
    gap(600);

    pulse(20, 8);
    gap(600);

    for (int f = 0; f < 6; f++) begin
      int np;
      np = $urandom_range(3, 1);
      for (int p = 0; p < np; p++) send_word(24'($urandom()), 2);
      gap($urandom_range(700, 600));
    end

    for (int p = 0; p < 257; p++) send_word(24'($urandom()), 1);
    gap(600);

    send_word(24'hC3C3C3, 0);
    for (int i = 0; i < 10; i++) send_bit(1'($urandom_range(1, 0)), 0);
    din = 1'b0;
    reset_n = 1'b0;
    model_reset();
    #1;
    check("mid_pixel_valid", 64'(pixel_valid), 64'd0);
    check("mid_grb_data", 64'(grb_data), 64'd0);
    check("mid_led_index", 64'(led_index), 64'd0);
    check("mid_frame_done", 64'(frame_done), 64'd0);
    check("mid_pixel_count", 64'(pixel_count), 64'd0);
    check("mid_err", 64'(err), 64'd0);
    repeat (3) @(posedge clk);
    #1;
    reset_n = 1'b1;
    send_word(24'h111111, 0);
    gap(600);
    w = 24'($urandom());
    send_word(w, 2);
    gap(600);
    hold(1'b0, 20);

    check("pix_q_empty", 64'(exp_pix_q.size()), 64'd0);
    check("frame_q_empty", 64'(exp_frame_q.size()), 64'd0);
    check("err_q_empty", 64'(exp_err_q.size()), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
